// File: rtl/hazard_bypass_if.sv
// hazard_bypass_if: ID-stage hazard/bypass bundle.
//   master: ID/pipeline control side; drives the decoded instruction, hold and
//           flush, and receives the operand selects, stall, issue and counter.
//   slave : hazard_bypass_unit side.
// SEL_W is derived here and must match the unit's view of NUM_FWD_STAGES.
interface hazard_bypass_if #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int NUM_SRC          = 2,
  parameter int NUM_FWD_STAGES   = 3,
  parameter int CNT_BITWIDTH     = 32
) ();
  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);

  logic                                  id_valid;
  logic [NUM_SRC*REG_NUM_BITWIDTH-1:0]   id_rs;
  logic [NUM_SRC-1:0]                    id_rs_used;
  logic [REG_NUM_BITWIDTH-1:0]           id_rd;
  logic                                  id_regWrite;
  logic [SEL_W-1:0]                      id_ready_stage;
  logic                                  hold;
  logic                                  flush;
  logic [NUM_SRC*SEL_W-1:0]              fwd_sel;
  logic                                  stall;
  logic                                  issue;
  logic [CNT_BITWIDTH-1:0]               stall_count;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_regWrite, id_ready_stage,
           hold, flush,
    input  fwd_sel, stall, issue, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_regWrite, id_ready_stage,
           hold, flush,
    output fwd_sel, stall, issue, stall_count
  );
endinterface

// File: rtl/hazard_bypass_unit.sv
// hazard_bypass_unit: tracks in-flight instructions from EX (stage 1) through
// WB (stage NUM_FWD_STAGES) in a shadow pipeline, selects per-operand bypass
// sources for the instruction in ID, and stalls ID when an operand's producer
// has not yet reached the stage that carries its result.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset (clears entry valids and counter)
//   bus   - hazard_bypass_if.slave: ID instruction, hold/flush in;
//           fwd_sel/stall/issue/stall_count out (all combinational except
//           stall_count, which is the counter register).
module hazard_bypass_unit #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int NUM_SRC          = 2,
  parameter int NUM_FWD_STAGES   = 3,
  parameter int CNT_BITWIDTH     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  hazard_bypass_if.slave  bus
);
  localparam int RB    = REG_NUM_BITWIDTH;
  localparam int N     = NUM_FWD_STAGES;
  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);
  localparam int CW    = CNT_BITWIDTH;

  // Shadow pipeline; array index k holds the instruction in stage k+1.
  logic [N-1:0]     vld_q, vld_d;
  logic [N-1:0]     wr_q, wr_d;
  logic [RB-1:0]    rd_q  [N];
  logic [RB-1:0]    rd_d  [N];
  logic [SEL_W-1:0] rdy_q [N];
  logic [SEL_W-1:0] rdy_d [N];
  logic [CW-1:0]    count_q, count_d;

  logic [NUM_SRC*SEL_W-1:0] sel;
  logic [NUM_SRC-1:0]       hazard;
  logic [RB-1:0]            rs_cur;
  logic                     found;
  logic                     stall;
  logic                     issue;

  // Ready stage 0 means "available after EX" and anything past WB is WB.
  function automatic logic [SEL_W-1:0] clamp_ready(input logic [SEL_W-1:0] r);
    if (r == '0)
      return SEL_W'(1);
    else if (r > SEL_W'(N))
      return SEL_W'(N);
    else
      return r;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Operand lookup: the lowest matching stage is the youngest writer, so it wins.
  always_comb begin
    sel    = '0;
    hazard = '0;
    rs_cur = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs_cur = bus.id_rs[i*RB +: RB];
      found  = 1'b0;
      if (bus.id_valid && bus.id_rs_used[i] && (rs_cur != '0)) begin
        for (int k = 0; k < N; k++) begin
          if (!found && vld_q[k] && wr_q[k] && (rd_q[k] == rs_cur)) begin
            found = 1'b1;
            if (SEL_W'(k + 1) >= rdy_q[k])
              sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
            else
              hazard[i] = 1'b1;
          end
        end
      end
    end
  end

  assign stall = (|hazard) && !bus.flush;
  // rst_n gating keeps issue low while reset is held, independent of inputs.
  assign issue = rst_n && bus.id_valid && !stall && !bus.flush && !bus.hold;

  assign bus.fwd_sel     = sel;
  assign bus.stall       = stall;
  assign bus.issue       = issue;
  assign bus.stall_count = count_q;

  // Hold freezes everything; otherwise shift one stage and insert ID or a bubble.
  always_comb begin
    vld_d   = vld_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    rdy_d   = rdy_q;
    count_d = count_q;
    if (!bus.hold) begin
      for (int k = N - 1; k >= 1; k--) begin
        vld_d[k] = vld_q[k-1];
        wr_d[k]  = wr_q[k-1];
        rd_d[k]  = rd_q[k-1];
        rdy_d[k] = rdy_q[k-1];
      end
      vld_d[0] = issue;
      wr_d[0]  = bus.id_regWrite;
      rd_d[0]  = bus.id_rd;
      rdy_d[0] = clamp_ready(bus.id_ready_stage);
      if (stall)
        count_d = sat_inc(count_q);
    end
  end

  // Control state: valids and the stall counter are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  // Entry payload is qualified by the valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    wr_q  <= wr_d;
    rd_q  <= rd_d;
    rdy_q <= rdy_d;
  end
endmodule

// File: doc/hazard_bypass_unit.md
# hazard_bypass_unit

Parametrised successor to the two-operand forwarding unit. It tracks every instruction in flight from EX through writeback in an internal shadow pipeline and drives per-operand bypass selects for NUM_SRC operands over NUM_FWD_STAGES stages. It detects use-before-ready hazards (load-use, multi-cycle results) and stalls decode, counting stall cycles. It sits beside the ID stage and feeds the EX operand muxes and the IF/ID hold logic.

## Interface
- REG_NUM_BITWIDTH, 5, architectural register index width
- NUM_SRC, 2, source operands checked per instruction
- NUM_FWD_STAGES, 3, tracked stages after ID (stage 1 = EX … stage N = WB), N ≥ 1
- CNT_BITWIDTH, 32, stall counter width
- Derived: SEL_W = clog2(NUM_FWD_STAGES+1)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  NUM_SRC*REG_NUM_BITWIDTH  source indices; operand i at bits [i*RB +: RB]
- id_rs_used  in  NUM_SRC  operand i is actually read
- id_rd  in  REG_NUM_BITWIDTH  destination index
- id_regWrite  in  1  instruction writes id_rd
- id_ready_stage  in  SEL_W  first stage whose output carries the result (ALU 1, load 2)
- hold  in  1  whole-pipeline freeze (memory wait)
- flush  in  1  ID instruction is wrong-path
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, s = forward from stage s
- stall  out  1  hold ID/IF, bubble into EX
- issue  out  1  ID instruction advances into EX this cycle
- stall_count  out  CNT_BITWIDTH  saturating count of stall cycles

## Operation
- Shadow pipeline: N entries {valid, rd, regWrite, ready}. Entry k describes the instruction currently in stage k.
- id_ready_stage 0 is treated as 1; values > N are treated as N.
- Per operand i, combinationally:
  - If !id_rs_used[i], or id_rs[i]==0, or !id_valid: sel 0, no hazard.
  - Otherwise find the lowest k with valid && regWrite && rd==id_rs[i]; the youngest match always wins.
  - If there is no match: sel 0.
  - If a match exists and k ≥ ready: sel k.
  - If a match exists and k < ready: hazard; sel driven 0.
- stall = any operand hazard && !flush. Flush suppresses stall.
- issue = id_valid && !stall && !flush && !hold.
- Clock update, priority hold > otherwise:
  - hold=1: all entries keep their value. stall_count is unchanged.
  - hold=0: entry k+1 ← entry k for k = 1..N-1, and the stage-N entry retires.
    - Entry 1 ← {1, id_rd, id_regWrite, clamped ready} if issue, otherwise a bubble (valid=0).
- If hold and flush coincide, flush has no effect. The controller keeps flush asserted until hold drops.
- stall_count increments when stall && !hold, and saturates at all-ones.
- A retired writer is visible through the register file (write-before-read in the register file).

## Timing
- fwd_sel, stall and issue are combinational from the entries and the current ID inputs. There are no registered outputs.
- An instruction issued in cycle t occupies stage k in cycle t+k (with no hold). It is invisible from cycle t+N+1.
- Load-use with ready=2: consumer directly behind the producer gets exactly 1 stall cycle, then sel 2.
- A result with ready=r and a consumer directly behind it gives r-1 stall cycles.
- Reset (asynchronous, any cycle, including mid-stall): all entries invalid, stall_count 0. Consequently stall=0 and fwd_sel=0. issue is forced 0 while rst_n=0.
- First rising edge after rst_n rises: normal operation; no stale hazards survive.

## Test plan
- ALU x5 issued, next instruction reads x5 on operand 0 → stall=0, fwd_sel[0]=1. One cycle later an independent reader of x5 → fwd_sel[0]=2.
- Load x7 (ready=2) followed by a reader of x7 → stall=1 for 1 cycle, stall_count=1. Next cycle stall=0, fwd_sel=2, issue=1.
- x3 written in stages 1 and 3 (ready=1) with reader of x3 → sel 1 (youngest wins). Reader of x0 with regWrite to x0 in flight → sel 0, no stall.
- Load-use stall with hold=1 for 3 cycles → stall stays 1, entries frozen, stall_count unchanged. After hold drops, exactly 1 counted stall cycle.
- flush=1 during load-use hazard → stall=0, issue=0, bubble enters stage 1. Next cycle entries are shifted with stage 1 invalid.
- rst_n pulled low mid-stall → stall=0, fwd_sel=0, stall_count=0 immediately. With CNT_BITWIDTH=4, 20 stall cycles → stall_count=15.
